rv32i_dmem_responder: RTL

//  Data-side responder for the rv32i_cpu load/store port. The CPU drives mem_we/mem_addr/mem_wdata/mem_wmask
//  and samples mem_rdata in the same cycle. This block owns byte-lane alignment, data RAM, and an MMIO window.

---
 rtl/rv32i_mmio_pkg.sv | 11 +
 rtl/rv32i_dmem_responder_if.sv | 10 +
 rtl/rv32i_uart_tx.sv | 80 ++++++++
 rtl/rv32i_dmem_responder.sv | 74 +++++++
 4 files changed

// File: rtl/rv32i_mmio_pkg.sv
// rv32i_mmio_pkg: MMIO register offsets, STATUS bit positions and UART TX states.
package rv32i_mmio_pkg;
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLE  = 4'h8;
  localparam logic [3:0] OFF_TOHOST = 4'hC;
  localparam int ST_FULL = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_OVF  = 2;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/rv32i_dmem_responder_if.sv
// rv32i_dmem_responder_if: CPU load/store port; rdata is combinational from the responder.
interface rv32i_dmem_responder_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  modport master (output mem_we, mem_addr, mem_wdata, mem_wmask, input mem_rdata);
  modport slave (input mem_we, mem_addr, mem_wdata, mem_wmask, output mem_rdata);
endinterface

// File: rtl/rv32i_uart_tx.sv
// rv32i_uart_tx: 8N1 transmitter with a TX FIFO, bit timer, frame FSM and shifter.
module rv32i_uart_tx import rv32i_mmio_pkg::*; #(
  parameter int CLK_DIV = 16,
  parameter int DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       uart_tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(CLK_DIV);
  logic [7:0] fifo_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic ovf_q, push_ok, pop, tmr_end;
  tx_state_e state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign push_ok = push && !full;
  assign pop = state_q == TX_IDLE && cnt_q != '0;
  assign tmr_end = tmr_q == TW'(CLK_DIV - 1);
  assign busy = state_q != TX_IDLE || cnt_q != '0;
  assign overflow = ovf_q;
  // Line state is decoded from the FSM so an async reset forces idle-high at once.
  assign uart_tx = state_q == TX_START ? 1'b0 : state_q == TX_DATA ? sh_q[0] : 1'b1;
  always_ff @(posedge clk)
    if (push_ok) fifo_q[wp_q] <= push_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      state_q <= TX_IDLE;
      tmr_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
    end else begin
      wp_q <= push_ok ? wp_q + 1'b1 : wp_q;
      rp_q <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      ovf_q <= ovf_q | (push & full);
      state_q <= state_d;
      tmr_q <= tmr_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
    end
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_end ? '0 : tmr_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    case (state_q)
      TX_IDLE: begin
        tmr_d = '0;
        if (pop) begin
          state_d = TX_START;
          sh_d = fifo_q[rp_q];
        end
      end
      TX_START: if (tmr_end) begin
        state_d = TX_DATA;
        bit_d = '0;
      end
      TX_DATA: if (tmr_end) begin
        sh_d = sh_q >> 1;
        bit_d = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? TX_STOP : TX_DATA;
      end
      default: if (tmr_end) state_d = TX_IDLE;
    endcase
  end
endmodule

// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: data RAM plus MMIO (UART TX, cycle counter, TOHOST halt) behind the CPU data port.
module rv32i_dmem_responder import rv32i_mmio_pkg::*; #(
  parameter int          DMEM_WORDS   = 1024,
  parameter logic [31:0] MMIO_BASE    = 32'h1000_0000,
  parameter int          CLK_DIV      = 16,
  parameter int          TXFIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  rv32i_dmem_responder_if.slave         bus,
  output logic                          uart_tx,
  output logic                          halt,
  output logic [31:0]                   halt_code
);
  localparam int AW = $clog2(DMEM_WORDS);
  logic [31:0] ram_q [DMEM_WORDS];
  logic [1:0] off;
  logic [3:0] eff_mask, mmio_off;
  logic [31:0] eff_wdata, word, status, mmio_rd, cycle_q, halt_code_q;
  logic [AW-1:0] idx;
  logic is_mmio, wr, ram_we, tx_push, tohost_we, halt_q;
  logic tx_full, tx_busy, tx_ovf, unused_addr;
  assign off = bus.mem_addr[1:0];
  // Lanes shifted past byte 3 fall off, so misaligned stores never spill into the next word.
  assign eff_mask = bus.mem_wmask << off;
  assign eff_wdata = bus.mem_wdata << {off, 3'b000};
  assign is_mmio = bus.mem_addr[31:28] == MMIO_BASE[31:28];
  assign mmio_off = bus.mem_addr[3:0];
  assign idx = bus.mem_addr[2 +: AW];
  assign unused_addr = ^bus.mem_addr;
  assign wr = bus.mem_we && !halt_q;
  assign ram_we = wr && !is_mmio;
  assign tx_push = wr && is_mmio && mmio_off == OFF_TXDATA && eff_mask[0];
  assign tohost_we = wr && is_mmio && mmio_off == OFF_TOHOST;
  always_comb begin
    status = '0;
    status[ST_FULL] = tx_full;
    status[ST_BUSY] = tx_busy;
    status[ST_OVF] = tx_ovf;
  end
  assign mmio_rd = mmio_off == OFF_STATUS ? status :
                   mmio_off == OFF_CYCLE  ? cycle_q :
                   mmio_off == OFF_TOHOST ? halt_code_q : '0;
  assign word = is_mmio ? mmio_rd : ram_q[idx];
  assign bus.mem_rdata = word >> {off, 3'b000};
  assign halt = halt_q;
  assign halt_code = halt_code_q;
  always_ff @(posedge clk)
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (eff_mask[b]) ram_q[idx][8*b +: 8] <= eff_wdata[8*b +: 8];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cycle_q <= '0;
      halt_q <= 1'b0;
      halt_code_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (tohost_we) begin
        halt_q <= 1'b1;
        halt_code_q <= bus.mem_wdata;
      end
    end
  rv32i_uart_tx #(.CLK_DIV(CLK_DIV), .DEPTH(TXFIFO_DEPTH)) u_tx (
    .clk(clk),
    .reset(reset),
    .push(tx_push),
    .push_data(eff_wdata[7:0]),
    .full(tx_full),
    .busy(tx_busy),
    .overflow(tx_ovf),
    .uart_tx(uart_tx)
  );
endmodule
